branch_resolver: RTL and testbench
==================================

# branch_resolver

Stage-3 branch resolution unit and the update/feedback end of the branch target buffer protocol. It carries each fetched PC and its taken prediction from IF (stage 1) through ID (stage 2) to EX (stage 3). At EX it evaluates the branch or jump and drives the BTB resolution inputs: PC, is-branch, actual taken, predicted taken, and resolved target. It consumes the BTB's flush to squash younger in-flight slots, and keeps saturating branch/mispredict counters.

## Interface
- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `memory_stall` in 1: freezes all stage registers and counters.
- `valid_1` in 1: IF slot holds a real instruction.
- `pc_1` in 32: IF PC, the same value the BTB sees as its stage-1 PC.
- `pred_taken_1` in 1: BTB taken prediction for `pc_1`.
- `flush_i` in 1: BTB flush, acting on the resolution currently presented.
- `is_br_3` in 1: EX instruction is a conditional branch.
- `is_jal_3` in 1: EX instruction is JAL.
- `is_jalr_3` in 1: EX instruction is JALR.
- `funct3_3` in 3: branch condition field.
- `rs1_3` in 32: forwarded operand 1.
- `rs2_3` in 32: forwarded operand 2.
- `imm_3` in 32: sign-extended immediate.
- `instructionPC_3` out 32: stage-3 PC.
- `is_branchInst_3` out 1: valid stage-3 branch or jump.
- `taken_3` out 1: actual outcome.
- `prev_taken_3` out 1: prediction carried from IF.
- `target_3` out 32: correct next PC.
- `br_cnt` out CNT_W: resolved branches/jumps.
- `mis_cnt` out CNT_W: resolutions that caused a flush.

## Operation
- Stage registers:
  - s2 = {v2, pc2, p2}
  - s3 = {v3, pc3, p3}
- When `memory_stall` = 0:
  - s2 ← {`valid_1`, `pc_1`, `pred_taken_1`}
  - s3 ← s2
- When `memory_stall` = 0 and `flush_i` = 1: v2 ← 0 and v3 ← 0. PCs and predictions still shift.
- When `memory_stall` = 1: s2, s3 and the counters hold. `flush_i` is ignored.
- Condition from `funct3_3`:
  - 000 eq, 001 ne
  - 100 signed lt, 101 signed ge
  - 110 unsigned lt, 111 unsigned ge
  - 010/011 never taken
- Stage-3 outputs:
  - `is_branchInst_3` = v3 & (`is_br_3` | `is_jal_3` | `is_jalr_3`)
  - `taken_3` = `is_branchInst_3` & (jal | jalr | (br & cond))
  - `prev_taken_3` = v3 & p3
  - `instructionPC_3` = pc3
- `target_3`:
  - JALR taken: (`rs1_3` + `imm_3`) & ~1
  - Branch/JAL taken: pc3 + `imm_3`
  - Otherwise: pc3 + 4
  - All adds are 32-bit modulo 2^32; carry is dropped.
- Counters, updated only when `memory_stall` = 0:
  - `br_cnt` += 1 when `is_branchInst_3`
  - `mis_cnt` += 1 when `is_branchInst_3` & `flush_i`
  - Both saturate at 2^CNT_W−1.
- A flush with v3 = 0 still squashes s2/s3, because the BTB owns the flush decision. It does not increment `mis_cnt`.

## Timing
- Reset values:
  - All stage registers 0, so `instructionPC_3` = 0 and `is_branchInst_3` = `taken_3` = `prev_taken_3` = 0.
  - `target_3` = 32'h4.
  - `br_cnt` = `mis_cnt` = 0.
- Reset applies immediately on `rst_n` falling, including mid-stall or mid-flush. The first update is on the first rising edge after `rst_n` rises.
- Latency: IF to stage-3 outputs is 2 unstalled edges. Each stall cycle adds one.
- All stage-3 outputs are combinational from s3 and the `*_3` inputs, valid in the same cycle.
- `flush_i` takes effect at the same edge the BTB commits its update. The instruction entering s3 at that edge arrives invalid.
- Back-to-back flushes are legal. Each one kills both younger slots.

## Test plan
- Reset:
  - Stimulus: assert `rst_n` = 0 asynchronously mid-cycle.
  - Response: all outputs immediately take their reset values, including `target_3` = 4.
- Taken BEQ mispredicted:
  - Stimulus: `pc_1` = 0x100, `pred_taken_1` = 0; two edges later `is_br_3` = 1, `funct3_3` = 000, `rs1_3` = `rs2_3` = 5, `imm_3` = 0x20.
  - Response: `taken_3` = 1, `prev_taken_3` = 0, `target_3` = 0x120.
  - Then drive `flush_i` = 1. Required: next-cycle `is_branchInst_3` = 0, and `mis_cnt` = 1.
- BLTU/BLT sign check:
  - Stimulus: `rs1_3` = 0xFFFFFFFF, `rs2_3` = 1, BLTU.
  - Response: not taken, `target_3` = pc3 + 4.
  - Same operands with BLT: taken.
- JALR:
  - Stimulus: `rs1_3` = 0x1003, `imm_3` = 0.
  - Response: `target_3` = 0x1002, `taken_3` = 1.
- Stall:
  - Stimulus: hold `memory_stall` = 1 for 3 cycles while `pc_1` changes, with `flush_i` = 1.
  - Response: s2/s3 and counters unchanged. On release, shifting resumes.
- Saturation:
  - Stimulus: `CNT_W` = 4, 20 flushed branches.
  - Response: `br_cnt` = `mis_cnt` = 15.

Source files
------------

// File: rtl/branch_resolver_if.sv
// Resolution bus between the EX-stage branch resolver and the branch target buffer.
// The resolver presents each resolved branch; the BTB answers with a flush in the same cycle.
interface branch_resolver_if;
  logic        flush_i;
  logic [31:0] instructionPC_3;
  logic        is_branchInst_3;
  logic        taken_3;
  logic        prev_taken_3;
  logic [31:0] target_3;

  modport master (
    input  flush_i,
    output instructionPC_3,
    output is_branchInst_3,
    output taken_3,
    output prev_taken_3,
    output target_3
  );

  modport slave (
    output flush_i,
    input  instructionPC_3,
    input  is_branchInst_3,
    input  taken_3,
    input  prev_taken_3,
    input  target_3
  );
endinterface

// File: rtl/branch_resolver.sv
// Stage-3 branch resolver: carries IF PC/prediction to EX, resolves branches and jumps,
// feeds the BTB resolution bus, honours its flush and keeps saturating branch/mispredict counters.
module branch_resolver #(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memory_stall,
  input  logic              valid_1,
  input  logic [31:0]       pc_1,
  input  logic              pred_taken_1,
  input  logic              is_br_3,
  input  logic              is_jal_3,
  input  logic              is_jalr_3,
  input  logic [2:0]        funct3_3,
  input  logic [31:0]       rs1_3,
  input  logic [31:0]       rs2_3,
  input  logic [31:0]       imm_3,
  branch_resolver_if.master res,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  mis_cnt
);

  localparam int unsigned XLEN = 32;

  logic            v2, v3, p2, p3;
  logic [XLEN-1:0] pc2, pc3;

  logic            cond;
  logic            is_branch;
  logic            taken;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;

  // IF -> ID -> EX pipeline; a flush kills validity but lets PCs and predictions keep shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      pc2 <= '0;
      p2  <= 1'b0;
      v3  <= 1'b0;
      pc3 <= '0;
      p3  <= 1'b0;
    end else if (!memory_stall) begin
      v2  <= valid_1 & ~res.flush_i;
      pc2 <= pc_1;
      p2  <= pred_taken_1;
      v3  <= v2 & ~res.flush_i;
      pc3 <= pc2;
      p3  <= p2;
    end
  end

  // Branch condition decode
  always_comb begin
    cond = 1'b0;
    unique case (funct3_3)
      3'b000:  cond = (rs1_3 == rs2_3);
      3'b001:  cond = (rs1_3 != rs2_3);
      3'b100:  cond = ($signed(rs1_3) <  $signed(rs2_3));
      3'b101:  cond = ($signed(rs1_3) >= $signed(rs2_3));
      3'b110:  cond = (rs1_3 <  rs2_3);
      3'b111:  cond = (rs1_3 >= rs2_3);
      default: cond = 1'b0;
    endcase
  end

  assign is_branch = v3 & (is_br_3 | is_jal_3 | is_jalr_3);
  assign taken     = is_branch & (is_jal_3 | is_jalr_3 | (is_br_3 & cond));
  assign jalr_sum  = rs1_3 + imm_3;

  // JALR takes priority should the decoder ever flag more than one kind
  always_comb begin
    target = pc3 + XLEN'(4);
    if (taken && is_jalr_3) begin
      target = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (taken) begin
      target = pc3 + imm_3;
    end
  end

  assign res.instructionPC_3 = pc3;
  assign res.is_branchInst_3 = is_branch;
  assign res.taken_3         = taken;
  assign res.prev_taken_3    = v3 & p3;
  assign res.target_3        = target;

  // Saturating performance counters, frozen with the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else if (!memory_stall) begin
      if (is_branch && (br_cnt != '1)) begin
        br_cnt <= br_cnt + CNT_W'(1);
      end
      if (is_branch && res.flush_i && (mis_cnt != '1)) begin
        mis_cnt <= mis_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: a default-width instance and a CNT_W=4 instance
// share all stimulus; expected values are hand-computed constants.
module tb_branch_resolver;

  logic        clk;
  logic        rst_n;
  logic        memory_stall;
  logic        valid_1;
  logic [31:0] pc_1;
  logic        pred_taken_1;
  logic        flush;
  logic        is_br_3, is_jal_3, is_jalr_3;
  logic [2:0]  funct3_3;
  logic [31:0] rs1_3, rs2_3, imm_3;
  logic [31:0] br_cnt, mis_cnt;
  logic [3:0]  br_cnt_sat, mis_cnt_sat;

  int n_vec;
  int n_err;

  branch_resolver_if res_if ();
  branch_resolver_if res_sat_if ();

  assign res_if.flush_i     = flush;
  assign res_sat_if.flush_i = flush;

  branch_resolver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .memory_stall (memory_stall),
    .valid_1      (valid_1),
    .pc_1         (pc_1),
    .pred_taken_1 (pred_taken_1),
    .is_br_3      (is_br_3),
    .is_jal_3     (is_jal_3),
    .is_jalr_3    (is_jalr_3),
    .funct3_3     (funct3_3),
    .rs1_3        (rs1_3),
    .rs2_3        (rs2_3),
    .imm_3        (imm_3),
    .res          (res_if.master),
    .br_cnt       (br_cnt),
    .mis_cnt      (mis_cnt)
  );

  branch_resolver #(.CNT_W(4)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .memory_stall (memory_stall),
    .valid_1      (valid_1),
    .pc_1         (pc_1),
    .pred_taken_1 (pred_taken_1),
    .is_br_3      (is_br_3),
    .is_jal_3     (is_jal_3),
    .is_jalr_3    (is_jalr_3),
    .funct3_3     (funct3_3),
    .rs1_3        (rs1_3),
    .rs2_3        (rs2_3),
    .imm_3        (imm_3),
    .res          (res_sat_if.master),
    .br_cnt       (br_cnt_sat),
    .mis_cnt      (mis_cnt_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end (got timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic v, input logic [31:0] pc, input logic p);
    valid_1      = v;
    pc_1         = pc;
    pred_taken_1 = p;
  endtask

  task automatic ex(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    is_br_3   = br;
    is_jal_3  = jal;
    is_jalr_3 = jalr;
    funct3_3  = f3;
    rs1_3     = a;
    rs2_3     = b;
    imm_3     = imm;
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"},    res_if.instructionPC_3, 32'h0);
    chk({tag, "_isb"},   32'(res_if.is_branchInst_3), 32'h0);
    chk({tag, "_tkn"},   32'(res_if.taken_3), 32'h0);
    chk({tag, "_prev"},  32'(res_if.prev_taken_3), 32'h0);
    chk({tag, "_tgt"},   res_if.target_3, 32'h4);
    chk({tag, "_br"},    br_cnt, 32'h0);
    chk({tag, "_mis"},   mis_cnt, 32'h0);
    chk({tag, "_brs"},   32'(br_cnt_sat), 32'h0);
    chk({tag, "_miss"},  32'(mis_cnt_sat), 32'h0);
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    memory_stall = 1'b0;
    flush        = 1'b0;
    feed(1'b0, 32'h0, 1'b0);
    ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);

    repeat (2) tick();
    chk_reset("rst0");
    rst_n = 1'b1;

    // Mispredicted taken BEQ followed by a BTB flush
    feed(1'b1, 32'h100, 1'b0); tick();
    feed(1'b1, 32'h104, 1'b0); tick();
    feed(1'b1, 32'h108, 1'b0);
    ex(1'b1, 1'b0, 1'b0, 3'b000, 32'd5, 32'd5, 32'h20);
    chk("beq_pc",   res_if.instructionPC_3, 32'h100);
    chk("beq_isb",  32'(res_if.is_branchInst_3), 32'h1);
    chk("beq_tkn",  32'(res_if.taken_3), 32'h1);
    chk("beq_prev", 32'(res_if.prev_taken_3), 32'h0);
    chk("beq_tgt",  res_if.target_3, 32'h120);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("fl_isb",  32'(res_if.is_branchInst_3), 32'h0);
    chk("fl_pc",   res_if.instructionPC_3, 32'h104);
    chk("fl_tgt",  res_if.target_3, 32'h108);
    chk("fl_br",   br_cnt, 32'd1);
    chk("fl_mis",  mis_cnt, 32'd1);
    chk("fl_miss", 32'(mis_cnt_sat), 32'd1);
    feed(1'b1, 32'h10C, 1'b0); tick();
    chk("fl2_isb", 32'(res_if.is_branchInst_3), 32'h0);
    chk("fl2_pc",  res_if.instructionPC_3, 32'h108);
    chk("fl2_br",  br_cnt, 32'd1);

    // Signed vs unsigned compares on 0xFFFFFFFF vs 1
    feed(1'b1, 32'h300, 1'b1); tick();
    ex(1'b1, 1'b0, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h40);
    chk("bltu_pc",  res_if.instructionPC_3, 32'h10C);
    chk("bltu_tkn", 32'(res_if.taken_3), 32'h0);
    chk("bltu_tgt", res_if.target_3, 32'h110);
    ex(1'b1, 1'b0, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h40);
    chk("blt_tkn",  32'(res_if.taken_3), 32'h1);
    chk("blt_tgt",  res_if.target_3, 32'h14C);
    ex(1'b1, 1'b0, 1'b0, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h40);
    chk("bge_tkn",  32'(res_if.taken_3), 32'h0);
    ex(1'b1, 1'b0, 1'b0, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h40);
    chk("bgeu_tkn", 32'(res_if.taken_3), 32'h1);
    ex(1'b1, 1'b0, 1'b0, 3'b010, 32'd7, 32'd7, 32'h40);
    chk("f010_tkn", 32'(res_if.taken_3), 32'h0);
    chk("f010_isb", 32'(res_if.is_branchInst_3), 32'h1);
    ex(1'b1, 1'b0, 1'b0, 3'b001, 32'd7, 32'd7, 32'h40);
    chk("bne_tkn",  32'(res_if.taken_3), 32'h0);
    feed(1'b1, 32'h304, 1'b0); tick();
    chk("cmp_br",   br_cnt, 32'd2);
    chk("cmp_mis",  mis_cnt, 32'd1);

    // JALR clears bit 0; JAL with a negative offset
    ex(1'b0, 1'b0, 1'b1, 3'b000, 32'h1003, 32'h0, 32'h0);
    chk("jalr_pc",   res_if.instructionPC_3, 32'h300);
    chk("jalr_tkn",  32'(res_if.taken_3), 32'h1);
    chk("jalr_tgt",  res_if.target_3, 32'h1002);
    chk("jalr_prev", 32'(res_if.prev_taken_3), 32'h1);
    ex(1'b0, 1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'hFFFF_FFF0);
    chk("jal_tkn",   32'(res_if.taken_3), 32'h1);
    chk("jal_tgt",   res_if.target_3, 32'h2F0);

    // Stall freezes stages and counters and masks the flush
    memory_stall = 1'b1;
    flush        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      feed(1'b1, 32'h400 + 32'(i * 4), 1'b1);
      tick();
      chk("stl_pc",  res_if.instructionPC_3, 32'h300);
      chk("stl_isb", 32'(res_if.is_branchInst_3), 32'h1);
      chk("stl_br",  br_cnt, 32'd2);
      chk("stl_mis", mis_cnt, 32'd1);
    end
    memory_stall = 1'b0;
    flush        = 1'b0;
    feed(1'b1, 32'h500, 1'b0);
    tick();
    chk("rel_pc",   res_if.instructionPC_3, 32'h304);
    chk("rel_isb",  32'(res_if.is_branchInst_3), 32'h1);
    chk("rel_prev", 32'(res_if.prev_taken_3), 32'h0);
    chk("rel_br",   br_cnt, 32'd3);
    chk("rel_mis",  mis_cnt, 32'd1);
    ex(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    tick();
    chk("rel2_pc",  res_if.instructionPC_3, 32'h500);
    chk("rel2_br",  br_cnt, 32'd3);

    // Asynchronous reset mid-cycle, during a stall and a flush
    ex(1'b1, 1'b1, 1'b1, 3'b000, 32'd1, 32'd1, 32'h80);
    memory_stall = 1'b1;
    flush        = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("rst1");
    tick();
    chk_reset("rst2");
    rst_n        = 1'b1;
    memory_stall = 1'b0;
    flush        = 1'b0;

    // Twenty flushed branches: the 4-bit counters stick at 15
    feed(1'b1, 32'h800, 1'b0);
    ex(1'b1, 1'b0, 1'b0, 3'b000, 32'd9, 32'd9, 32'h10);
    for (int i = 0; i < 20; i++) begin
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    chk("sat_brs",  32'(br_cnt_sat), 32'd15);
    chk("sat_miss", 32'(mis_cnt_sat), 32'd15);
    chk("sat_br",   br_cnt, 32'd20);
    chk("sat_mis",  mis_cnt, 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
